// File: rtl/fadd_pkg.sv
// Shared FP32 adder constants: rounding-mode codes, field widths, special magnitudes.
// No logic; imported by the align, calc and normalise stages.
// No flow control.
package fadd_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RDN = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RTZ = 2'b11;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG = 31'h7F80_0000;
    localparam logic [30:0] MAX_MAG = 31'h7F7F_FFFF;

    // N1 register contents: normalised magnitude plus flags carried to rounding
    typedef struct packed {
        logic              nan;
        logic              inf;
        logic [FRAC_W-1:0] nan_frac;
        logic              sign;
        logic [1:0]        rm;
        logic signed [9:0] exp;
        logic [26:0]       frac;
    } n1_t;

endpackage

// File: rtl/fadd_lzc28.sv
// Leading-zero count of a 27-bit magnitude; 27 when the input is all zero.
// Latency: combinational.
// No flow control.
module fadd_lzc28 (
    input  logic [26:0] a,
    output logic [4:0]  lz
);

    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (a[i]) lz = 5'(26 - i);
        end
    end

endmodule

// File: rtl/fadd_norm_pipe.sv
// FP32 adder final stage: normalise (N1), round and pack (N2) into an IEEE-754 single.
// Latency: 2 cycles, 1 word/cycle.
// Backpressure: valid/ready; a stalled output holds s/out_valid, in_ready drops once both stages are full.
module fadd_norm_pipe
    import fadd_pkg::*;
#(
    parameter bit NAN_PROPAGATE = 1'b1
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  rm,
    input  logic        s_is_nan,
    input  logic        s_is_inf,
    input  logic [22:0] inf_nan_frac,
    input  logic        sign,
    input  logic [7:0]  temp_exp,
    input  logic [27:0] cal_frac,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] s
);

    logic        n1_valid, n2_valid;
    logic        n1_load, n2_load;
    n1_t         n1_d, n1_q;
    logic [31:0] s_d;
    logic [4:0]  lz;

    assign n2_load   = ~n2_valid | out_ready;
    assign n1_load   = ~n1_valid | n2_load;
    assign in_ready  = n1_load;
    assign out_valid = n2_valid;

    fadd_lzc28 u_lzc (
        .a  (cal_frac[26:0]),
        .lz (lz)
    );

    // N1: normalise
    always_comb begin
        n1_d          = '0;
        n1_d.nan      = s_is_nan;
        n1_d.inf      = s_is_inf;
        n1_d.nan_frac = inf_nan_frac;
        n1_d.sign     = sign;
        n1_d.rm       = rm;
        if (cal_frac[27]) begin
            n1_d.frac = {cal_frac[27:2], cal_frac[1] | cal_frac[0]};
            n1_d.exp  = $signed({2'b00, temp_exp}) + 10'sd1;
        end else if (cal_frac[26:0] == 27'd0) begin
            // No op code arrives here: a zero from a nonzero exponent can only be a cancellation
            n1_d.frac = '0;
            n1_d.exp  = '0;
            if (temp_exp != 8'd0) n1_d.sign = (rm == RM_RDN);
        end else if ({2'b00, temp_exp} > {5'b00000, lz}) begin
            n1_d.frac = cal_frac[26:0] << lz;
            n1_d.exp  = $signed({2'b00, temp_exp}) - $signed({5'b00000, lz});
        end else if (temp_exp != 8'd0) begin
            n1_d.frac = cal_frac[26:0] << (temp_exp - 8'd1);
            n1_d.exp  = '0;
        end else begin
            n1_d.frac = cal_frac[26:0];
            n1_d.exp  = '0;
        end
    end

    // N2: round, renormalise, pack
    logic              g, r, st, lsb, inc;
    logic [24:0]       mant;
    logic [22:0]       m23;
    logic signed [9:0] exp_r;

    always_comb begin
        lsb = n1_q.frac[3];
        g   = n1_q.frac[2];
        r   = n1_q.frac[1];
        st  = n1_q.frac[0];
        case (n1_q.rm)
            RM_RNE:  inc = g & (r | st | lsb);
            RM_RDN:  inc = n1_q.sign & (g | r | st);
            RM_RUP:  inc = ~n1_q.sign & (g | r | st);
            default: inc = 1'b0;
        endcase
        mant  = {1'b0, n1_q.frac[26:3]} + {24'd0, inc};
        exp_r = n1_q.exp;
        if (mant[24]) begin
            m23   = mant[23:1];
            exp_r = n1_q.exp + 10'sd1;
        end else begin
            m23 = mant[22:0];
            if (n1_q.exp == 10'sd0 && mant[23]) exp_r = 10'sd1;
        end

        if (n1_q.nan) begin
            s_d = NAN_PROPAGATE ? {n1_q.sign, 8'hFF, n1_q.nan_frac} : QNAN;
        end else if (n1_q.inf) begin
            s_d = {n1_q.sign, INF_MAG};
        end else if (exp_r >= 10'sd255) begin
            case (n1_q.rm)
                RM_RNE:  s_d = {n1_q.sign, INF_MAG};
                RM_RDN:  s_d = n1_q.sign ? {1'b1, INF_MAG} : {1'b0, MAX_MAG};
                RM_RUP:  s_d = n1_q.sign ? {1'b1, MAX_MAG} : {1'b0, INF_MAG};
                default: s_d = {n1_q.sign, MAX_MAG};
            endcase
        end else begin
            s_d = {n1_q.sign, exp_r[7:0], m23};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            n1_valid <= 1'b0;
            n2_valid <= 1'b0;
            n1_q     <= '0;
            s        <= '0;
        end else begin
            if (n1_load) begin
                n1_valid <= in_valid;
                if (in_valid) n1_q <= n1_d;
            end
            if (n2_load) begin
                n2_valid <= n1_valid;
                if (n1_valid) s <= s_d;
            end
        end
    end

endmodule

// File: tb/tb_fadd_norm_pipe.sv
// Scoreboarded bench for fadd_norm_pipe: directed vectors with known results, random traffic
// against an independent bit-loop reference, stall, and mid-stream reset.
module tb_fadd_norm_pipe;

    typedef struct {
        logic        nan;
        logic        inf;
        logic [22:0] nfrac;
        logic        sign;
        logic [1:0]  rm;
        logic [7:0]  texp;
        logic [27:0] cf;
        bit          has_exp;
        logic [31:0] exp1;
        logic [31:0] exp0;
    } stim_t;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  rm = 2'b00;
    logic        s_is_nan = 1'b0, s_is_inf = 1'b0, sign = 1'b0;
    logic [22:0] inf_nan_frac = '0;
    logic [7:0]  temp_exp = '0;
    logic [27:0] cal_frac = '0;
    logic        in_ready, out_valid, in_ready0, out_valid0;
    logic [31:0] s, s0;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] q1[$];
    logic [31:0] q0[$];
    stim_t cur;
    bit    rand_rdy = 0;

    always #5 clk = ~clk;

    fadd_norm_pipe #(.NAN_PROPAGATE(1'b1)) dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready), .rm(rm),
        .s_is_nan(s_is_nan), .s_is_inf(s_is_inf), .inf_nan_frac(inf_nan_frac), .sign(sign),
        .temp_exp(temp_exp), .cal_frac(cal_frac), .out_valid(out_valid), .out_ready(out_ready), .s(s)
    );

    fadd_norm_pipe #(.NAN_PROPAGATE(1'b0)) dut0 (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready0), .rm(rm),
        .s_is_nan(s_is_nan), .s_is_inf(s_is_inf), .inf_nan_frac(inf_nan_frac), .sign(sign),
        .temp_exp(temp_exp), .cal_frac(cal_frac), .out_valid(out_valid0), .out_ready(out_ready), .s(s0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: shift one bit at a time from an effective exponent, then round and pack
    function automatic logic [31:0] model(input stim_t t, input bit prop);
        logic [27:0] v;
        logic [24:0] m;
        logic        inc;
        int          ee, be;
        if (t.nan) return prop ? {t.sign, 8'hFF, t.nfrac} : 32'h7FC0_0000;
        if (t.inf) return {t.sign, 8'hFF, 23'h0};
        v = t.cf;
        if (v == 28'd0) return {(t.texp != 8'd0) ? (t.rm == 2'b01) : t.sign, 31'h0};
        ee = (t.texp == 8'd0) ? 1 : int'(t.texp);
        if (v[27]) begin
            v  = {1'b0, v[27:2], v[1] | v[0]};
            ee = int'(t.texp) + 1;
        end
        while (v[26] == 1'b0 && ee > 1) begin
            v  = v << 1;
            ee = ee - 1;
        end
        case (t.rm)
            2'b00:   inc = v[2] & (v[1] | v[0] | v[3]);
            2'b01:   inc = t.sign & (v[2] | v[1] | v[0]);
            2'b10:   inc = ~t.sign & (v[2] | v[1] | v[0]);
            default: inc = 1'b0;
        endcase
        m = {1'b0, v[26:3]} + 25'(inc);
        if (m[24]) begin
            m  = m >> 1;
            ee = ee + 1;
        end
        be = m[23] ? ee : 0;
        if (be >= 255) begin
            case (t.rm)
                2'b00:   return {t.sign, 31'h7F80_0000};
                2'b01:   return t.sign ? 32'hFF80_0000 : 32'h7F7F_FFFF;
                2'b10:   return t.sign ? 32'hFF7F_FFFF : 32'h7F80_0000;
                default: return {t.sign, 31'h7F7F_FFFF};
            endcase
        end
        return {t.sign, be[7:0], m[22:0]};
    endfunction

    function automatic stim_t mk(input logic [7:0] te, input logic [27:0] cf, input logic [1:0] m,
                                 input logic sg, input logic [31:0] e1, input logic [31:0] e0);
        stim_t t;
        t.nan = 0; t.inf = 0; t.nfrac = '0; t.sign = sg; t.rm = m; t.texp = te; t.cf = cf;
        t.has_exp = 1; t.exp1 = e1; t.exp0 = e0;
        return t;
    endfunction

    // Transfers are decided at the posedge; sampling at negedge sees the same stable values
    always @(negedge clk) begin
        if (clrn && in_valid && in_ready) begin
            q1.push_back(cur.has_exp ? cur.exp1 : model(cur, 1'b1));
            q0.push_back(cur.has_exp ? cur.exp0 : model(cur, 1'b0));
        end
        if (clrn && out_valid && out_ready) begin
            if (q1.size() == 0) check("unexpected_out", 32'd1, 32'd0);
            else check("s", s, q1.pop_front());
        end
        if (clrn && out_valid0 && out_ready) begin
            if (q0.size() == 0) check("unexpected_out0", 32'd1, 32'd0);
            else check("s_nanp0", s0, q0.pop_front());
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input stim_t t);
        bit ok;
        int n;
        cur = t;
        s_is_nan = t.nan; s_is_inf = t.inf; inf_nan_frac = t.nfrac; sign = t.sign;
        rm = t.rm; temp_exp = t.texp; cal_frac = t.cf;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (q1.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_q1", 32'(q1.size()), 32'd0);
        check("drain_q0", 32'(q0.size()), 32'd0);
    endtask

    stim_t vec[$];
    stim_t t;
    logic [31:0] held;

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", s, 32'd0);
        clrn = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // first word alone: out_valid must rise exactly two edges after acceptance
        send(mk(8'h7F, 28'h800_0000, 2'b00, 1'b0, 32'h4000_0000, 32'h4000_0000));
        idle();
        @(negedge clk);
        check("lat_edge1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_edge2", 32'(out_valid), 32'd1);
        drain();

        vec.push_back(mk(8'h7F, 28'h200_0000, 2'b00, 1'b0, 32'h3F00_0000, 32'h3F00_0000));
        vec.push_back(mk(8'h7F, 28'h400_0004, 2'b00, 1'b0, 32'h3F80_0000, 32'h3F80_0000));
        vec.push_back(mk(8'h7F, 28'h400_0004, 2'b10, 1'b0, 32'h3F80_0001, 32'h3F80_0001));
        vec.push_back(mk(8'h7F, 28'h400_0004, 2'b11, 1'b0, 32'h3F80_0000, 32'h3F80_0000));
        vec.push_back(mk(8'h7F, 28'h400_000C, 2'b00, 1'b0, 32'h3F80_0002, 32'h3F80_0002));
        vec.push_back(mk(8'hFE, 28'h800_0000, 2'b00, 1'b0, 32'h7F80_0000, 32'h7F80_0000));
        vec.push_back(mk(8'hFE, 28'h800_0000, 2'b11, 1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF));
        vec.push_back(mk(8'hFE, 28'h800_0000, 2'b01, 1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF));
        vec.push_back(mk(8'hFE, 28'h800_0000, 2'b01, 1'b1, 32'hFF80_0000, 32'hFF80_0000));
        vec.push_back(mk(8'hFE, 28'h800_0000, 2'b10, 1'b1, 32'hFF7F_FFFF, 32'hFF7F_FFFF));
        vec.push_back(mk(8'h7F, 28'h000_0000, 2'b01, 1'b0, 32'h8000_0000, 32'h8000_0000));
        vec.push_back(mk(8'h7F, 28'h000_0000, 2'b00, 1'b1, 32'h0000_0000, 32'h0000_0000));
        vec.push_back(mk(8'h00, 28'h000_0000, 2'b00, 1'b1, 32'h8000_0000, 32'h8000_0000));
        vec.push_back(mk(8'h02, 28'h000_0100, 2'b00, 1'b0, 32'h0000_0040, 32'h0000_0040));
        vec.push_back(mk(8'h00, 28'h7FF_FFFC, 2'b00, 1'b0, 32'h0080_0000, 32'h0080_0000));
        t = mk(8'h00, 28'h0, 2'b00, 1'b0, 32'h7FC0_0001, 32'h7FC0_0000);
        t.nan = 1; t.nfrac = 23'h40_0001;
        vec.push_back(t);
        t = mk(8'h00, 28'h0, 2'b00, 1'b1, 32'hFF80_0000, 32'hFF80_0000);
        t.inf = 1;
        vec.push_back(t);
        t = mk(8'h00, 28'h0, 2'b00, 1'b1, 32'hFFC0_0003, 32'h7FC0_0000);
        t.nan = 1; t.inf = 1; t.nfrac = 23'h40_0003;
        vec.push_back(t);
        foreach (vec[i]) send(vec[i]);
        drain();

        // stall: two accepts fill the pipe, then output must hold
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(mk(8'h80, 28'h400_0000, 2'b00, 1'b0, 32'h4000_0000, 32'h4000_0000));
        send(mk(8'h81, 28'h400_0000, 2'b00, 1'b0, 32'h4080_0000, 32'h4080_0000));
        idle();
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_in_ready0", 32'(in_ready0), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        held = s;
        repeat (3) begin
            @(negedge clk);
            check("stall_s_hold", s, held);
            check("stall_valid_hold", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 6; i++)
            send(mk(8'(8'h82 + i), 28'h400_0000, 2'b00, 1'b0, {1'b0, 8'(8'h82 + i), 23'h0},
                    {1'b0, 8'(8'h82 + i), 23'h0}));
        drain();

        // random traffic with random backpressure
        rand_rdy = 1;
        for (int i = 0; i < 60; i++) begin
            t.nan = ($urandom_range(0, 15) == 0);
            t.inf = ($urandom_range(0, 15) == 0);
            t.nfrac = 23'($urandom);
            t.sign = 1'($urandom);
            t.rm = 2'($urandom);
            t.texp = 8'($urandom_range(0, 254));
            t.cf = 28'($urandom) >> $urandom_range(0, 27);
            if (t.texp == 8'd0) t.cf[27] = 1'b0;
            t.has_exp = 0; t.exp1 = '0; t.exp0 = '0;
            send(t);
        end
        rand_rdy = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        // reset while words are in flight
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(mk(8'h7F, 28'h400_0000, 2'b00, 1'b0, 32'h3F80_0000, 32'h3F80_0000));
        send(mk(8'h7F, 28'h400_0000, 2'b00, 1'b1, 32'hBF80_0000, 32'hBF80_0000));
        idle();
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 clrn = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_s", s, 32'd0);
        q1.delete();
        q0.delete();
        @(posedge clk);
        #1 clrn = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        send(mk(8'h7F, 28'h200_0000, 2'b00, 1'b0, 32'h3F00_0000, 32'h3F00_0000));
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
